// File: rtl/apb_uart_pkg.sv
// Shared APB/UART definitions: register map and the bridge FSM state encoding.
package apb_uart_pkg;

   localparam logic [31:0] CTRL_REG_ADDR  = 32'h0;
   localparam logic [31:0] STATS_REG_ADDR = 32'h1;
   localparam logic [31:0] TX_DATA_ADDR   = 32'h2;
   localparam logic [31:0] RX_DATA_ADDR   = 32'h3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// APB initiator: turns a valid/ready command into one APB transfer and returns
// the result on a valid/ready response, with an optional ACCESS-phase timeout.
module apb_master_bridge
   import apb_uart_pkg::*;
#(
   parameter int PADDR_WIDTH    = 32,
   parameter int PWDATA_WIDTH   = 32,
   parameter int PRDATA_WIDTH   = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [PADDR_WIDTH-1:0]  cmd_addr,
   input  logic [PWDATA_WIDTH-1:0] cmd_wdata,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [PRDATA_WIDTH-1:0] rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   output logic [PADDR_WIDTH-1:0]  PADDR,
   output logic                    PSEL,
   output logic                    PENABLE,
   output logic                    PWRITE,
   output logic [PWDATA_WIDTH-1:0] PWDATA,
   input  logic [PRDATA_WIDTH-1:0] PRDATA,
   input  logic                    PREADY,
   input  logic                    PSLVERR
);

   // A zero timeout still needs a 1-bit counter to keep the declaration legal.
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   apb_state_e                state_q, state_d;
   logic [PADDR_WIDTH-1:0]    paddr_q, paddr_d;
   logic [PWDATA_WIDTH-1:0]   pwdata_q, pwdata_d;
   logic                      pwrite_q, pwrite_d;
   logic [CNT_W-1:0]          wait_q, wait_d;
   logic [PRDATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                      err_q, err_d;
   logic                      tmo_q, tmo_d;
   logic                      timeout_hit;

   // Fires on the TIMEOUT_CYCLES-th PREADY-low ACCESS cycle.
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && !PREADY &&
                        ((int'(wait_q) + 1) >= TIMEOUT_CYCLES);

   always_comb begin
      state_d  = state_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      pwrite_d = pwrite_q;
      wait_d   = wait_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      tmo_d    = tmo_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               paddr_d  = cmd_addr;
               pwdata_d = cmd_wdata;
               pwrite_d = cmd_write;
               wait_d   = '0;
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            wait_d  = '0;
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (PREADY) begin
               rdata_d = pwrite_q ? '0 : PRDATA;
               err_d   = PSLVERR;
               tmo_d   = 1'b0;
               state_d = ST_RESP;
            end else if (timeout_hit) begin
               rdata_d = '0;
               err_d   = 1'b1;
               tmo_d   = 1'b1;
               state_d = ST_RESP;
            end else begin
               wait_d = wait_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q  <= ST_IDLE;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pwrite_q <= 1'b0;
         wait_q   <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         tmo_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         pwrite_q <= pwrite_d;
         wait_q   <= wait_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         tmo_q    <= tmo_d;
      end
   end

   assign cmd_ready   = (state_q == ST_IDLE) && !PRESET;
   assign PSEL        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
   assign PENABLE     = (state_q == ST_ACCESS);
   assign rsp_valid   = (state_q == ST_RESP);
   assign PADDR       = paddr_q;
   assign PWDATA      = pwdata_q;
   assign PWRITE      = pwrite_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;
   assign rsp_timeout = tmo_q;

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

APB initiator that converts a simple valid/ready command stream into single APB transfers and returns each result on a valid/ready response stream. It is the requester end of the APB bus that `apb_uart_wrapper` and future APB peripherals respond to. It lets on-chip logic or a debug front end program the UART's CTRL, STATS, TX_DATA and RX_DATA registers without hand-sequencing the APB phases. A programmable timeout keeps a non-responding slave from hanging the requester.

## Interface
Parameters:
- PADDR_WIDTH, 32, APB address width
- PWDATA_WIDTH, 32, APB write-data width
- PRDATA_WIDTH, 32, APB read-data width
- TIMEOUT_CYCLES, 256, number of ACCESS cycles allowed with PREADY low before abort; 0 disables the timeout

Ports:
- PCLK  in  1  the single clock; all logic is on its rising edge
- PRESET  in  1  reset, synchronous and active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  bridge accepts the command this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  PADDR_WIDTH  target address
- cmd_wdata  in  PWDATA_WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response this cycle
- rsp_rdata  out  PRDATA_WIDTH  read data; 0 for writes and for timeouts
- rsp_err  out  1  PSLVERR was sampled high, or a timeout occurred
- rsp_timeout  out  1  transfer was aborted by timeout
- PADDR, PSEL, PENABLE, PWRITE, PWDATA  out  —  APB request signals, widths as parameters
- PRDATA, PREADY, PSLVERR  in  —  APB completion signals

## Operation
FSM states: IDLE, SETUP, ACCESS, RESP.

- **IDLE**
  - cmd_ready = 1.
  - On cmd_valid: latch cmd_write, cmd_addr and cmd_wdata into PWRITE, PADDR and PWDATA, then go to SETUP.
- **SETUP**
  - Drive PSEL = 1, PENABLE = 0, then go to ACCESS unconditionally.
- **ACCESS**
  - Drive PSEL = 1, PENABLE = 1.
  - Sample PRDATA and PSLVERR only on a cycle with PREADY = 1.
  - On PREADY = 1:
    - capture rsp_rdata = PRDATA for reads, 0 for writes
    - capture rsp_err = PSLVERR, rsp_timeout = 0
    - go to RESP
  - Wait counter:
    - increments on each ACCESS cycle with PREADY = 0
    - when it reaches TIMEOUT_CYCLES, capture rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0, and go to RESP
- **RESP**
  - Drive PSEL = 0, PENABLE = 0, rsp_valid = 1.
  - Response fields are stable until rsp_valid && rsp_ready, then return to IDLE.

Rules common to all states:
- cmd_ready = 1 only in IDLE with PRESET low.
- PADDR, PWRITE and PWDATA are held stable from SETUP through the end of ACCESS and keep their values afterwards; they are not cleared.
- Only one transfer is outstanding at a time; there is no command or response buffering.
- The wait counter is cleared on entry to SETUP.

## Timing
- **Reset**, on a rising edge with PRESET high:
  - state IDLE
  - PSEL, PENABLE, PWRITE = 0; PADDR, PWDATA = 0
  - rsp_valid, rsp_err, rsp_timeout = 0; rsp_rdata = 0
  - cmd_ready = 0 while PRESET is high
- **Zero-wait transfer**, command accepted at edge T:
  - SETUP during cycle T+1
  - ACCESS during cycle T+2; the slave completes at edge T+3
  - RESP (rsp_valid = 1) from cycle T+3
  - PSEL is high for exactly 2 cycles, PENABLE for 1
- **Wait states**: each PREADY-low ACCESS cycle adds 1 cycle of latency.
- **Timeout**: rsp_valid rises the cycle after the TIMEOUT_CYCLES-th PREADY-low ACCESS cycle. PSEL and PENABLE drop in the same cycle.
- **Back-to-back**: a response consumed at edge R gives IDLE at R+1. The next command can be accepted at edge R+1, so there is a minimum 1-cycle bubble. A command presented during RESP is not accepted.
- **Reset mid-transfer**: PSEL and PENABLE drop at that edge and any pending response is discarded. The slave side of an aborted access is undefined and is not checked.
- **PSLVERR without PREADY**: ignored.

## Structure
- The shared package `apb_uart_pkg` holds:
  - the register-address constants CTRL_REG_ADDR = 0x0, STATS_REG_ADDR = 0x1, TX_DATA_ADDR = 0x2, RX_DATA_ADDR = 0x3
  - the FSM state encoding, shared with `apb_uart_wrapper` and the bench
- No sub-module: the FSM, the wait counter and the response registers live in one module. The counter width is `$clog2(TIMEOUT_CYCLES+1)`.

## Test plan
- **Zero-wait write**: write TX_DATA_ADDR with 0x0000_0001 and PREADY tied high.
  - PSEL high 2 cycles, PENABLE high 1 cycle, PADDR = 0x2 and PWDATA = 0x1 stable throughout.
  - rsp_valid at T+3 with rsp_err = 0 and rsp_rdata = 0.
- **Read with wait states**: read STATS_REG_ADDR; the slave drives PREADY low for 3 ACCESS cycles, then returns PRDATA = 0x0000_0005.
  - rsp_valid at T+6 with rsp_rdata = 0x5 and rsp_err = 0.
- **Slave error**: read RX_DATA_ADDR; the slave returns PREADY = 1, PSLVERR = 1, PRDATA = 0xA5.
  - rsp_err = 1, rsp_timeout = 0, rsp_rdata = 0xA5.
- **Timeout**: with TIMEOUT_CYCLES = 16 and PREADY held low, issue a write to CTRL_REG_ADDR.
  - After 16 ACCESS cycles PSEL and PENABLE drop.
  - rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
- **Back-pressure and back-to-back**: hold rsp_ready low for 5 cycles with a second command already valid.
  - The response stays stable and cmd_ready stays 0.
  - After rsp_ready is asserted, the second command is accepted exactly 1 cycle later.
- **Reset mid-transfer**: assert PRESET for 1 cycle during ACCESS.
  - PSEL and PENABLE are 0 at the next edge, no rsp_valid appears, and cmd_ready = 1 the following cycle.
